// File: rtl/factorial_pkg.sv
// Shared types and constants for the factorial engine.
package factorial_pkg;

  localparam int N_W = 4;
  localparam int F_W = 16;

  localparam logic [15:0] ONE = 16'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/factorial_mul.sv
// Combinational unsigned A_W x B_W shift-add multiplier; the product is
// truncated to A_W bits, so results wrap modulo 2^A_W.
module factorial_mul #(
  parameter int A_W = factorial_pkg::F_W,
  parameter int B_W = factorial_pkg::N_W
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W-1:0] prod
);

  // Accumulate a shifted copy of a for every set bit of b.
  always_comb begin
    prod = '0;
    for (int i = 0; i < B_W; i++) begin
      if (b[i]) begin
        prod = prod + (a << i);
      end
    end
  end

endmodule

// File: rtl/factorial_unit.sv
// Iterative factorial engine: one multiply per clock, level start/done
// handshake, registered result.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; fact holds the last result
//   CALC  | acc *= cnt, cnt -= 1 each edge; finishes when cnt == 2
//   DONE  | done high with result on fact until start drops
module factorial_unit
  import factorial_pkg::*;
#(
  parameter int N_W = factorial_pkg::N_W,
  parameter int F_W = factorial_pkg::F_W
) (
  input  logic           clk,
  input  logic           reset_n,   // active-high synchronous reset
  input  logic           start,
  input  logic [N_W-1:0] data1,
  output logic           done,
  output logic [F_W-1:0] fact
);

  state_t         state_q;
  state_t         state_nxt;
  logic [F_W-1:0] acc_q;
  logic [N_W-1:0] cnt_q;
  logic [F_W-1:0] prod;

  logic           small_op;
  logic           last_step;
  logic           load_op;
  logic           step;
  logic           fact_ld_one;
  logic           fact_ld_prod;
  logic           done_set;
  logic           done_clr;

  // 0! and 1! skip the multiply loop entirely.
  assign small_op  = (data1 <= N_W'(1));
  assign last_step = (cnt_q == N_W'(2));

  factorial_mul #(
    .A_W (F_W),
    .B_W (N_W)
  ) u_mul (
    .a    (acc_q),
    .b    (cnt_q),
    .prod (prod)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = small_op ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control decoded from the current state.
  always_comb begin
    load_op      = 1'b0;
    step         = 1'b0;
    fact_ld_one  = 1'b0;
    fact_ld_prod = 1'b0;
    done_set     = 1'b0;
    done_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_op     = 1'b1;
          fact_ld_one = small_op;
          done_set    = small_op;
        end
      end
      CALC: begin
        step         = 1'b1;
        fact_ld_prod = last_step;
        done_set     = last_step;
      end
      DONE: begin
        done_clr = !start;
      end
      default: ;
    endcase
  end

  // Operand, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      acc_q <= F_W'(ONE);
      cnt_q <= '0;
      fact  <= '0;
      done  <= 1'b0;
    end else begin
      if (load_op) begin
        cnt_q <= data1;
        acc_q <= F_W'(ONE);
      end else if (step) begin
        cnt_q <= cnt_q - N_W'(1);
        acc_q <= prod;
      end
      if (fact_ld_one) begin
        fact <= F_W'(ONE);
      end else if (fact_ld_prod) begin
        fact <= prod;
      end
      if (done_set) begin
        done <= 1'b1;
      end else if (done_clr) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_factorial_unit.sv
// Directed bench for factorial_unit with hand-computed factorials.
module tb_factorial_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  data1;
  logic        done;
  logic [15:0] fact;

  int n_cmp = 0;
  int n_bad = 0;

  factorial_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .data1   (data1),
    .done    (done),
    .fact    (fact)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are changed and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edge, then count edges until done is seen (bounded).
  task automatic wait_done(output int edges);
    tick();
    edges = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      edges++;
      if (done) break;
    end
  endtask

  // Drop start until the engine is back in IDLE.
  task automatic release_start();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    int edges;
    reset_n = 1'b1;
    start   = 1'b1;
    data1   = 4'd6;
    tick();
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done got=%0b want=0", done);
    end
    n_cmp++;
    if (fact !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_fact got=%0d want=0", fact);
    end
    reset_n = 1'b0;
    tick();
    edges = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      edges++;
      if (done) break;
      n_cmp++;
      if (fact !== 16'd0) begin
        n_bad++;
        $display("FAIL reset_fact_busy edge=%0d got=%0d want=0", edges, fact);
      end
    end
    n_cmp++;
    if (edges != 5) begin
      n_bad++;
      $display("FAIL first6_latency got=%0d want=5", edges);
    end
    n_cmp++;
    if (fact !== 16'd720) begin
      n_bad++;
      $display("FAIL first6_fact got=%0d want=720", fact);
    end
  endtask

  task automatic test_small();
    logic [3:0]  ops  [3] = '{4'd0, 4'd1, 4'd2};
    logic [15:0] exps [3] = '{16'd1, 16'd1, 16'd2};
    int edges;
    for (int k = 0; k < 3; k++) begin
      release_start();
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL small_release n=%0d got=%0b want=0", ops[k], done);
      end
      start = 1'b1;
      data1 = ops[k];
      wait_done(edges);
      n_cmp++;
      if (edges != 1) begin
        n_bad++;
        $display("FAIL small_latency n=%0d got=%0d want=1", ops[k], edges);
      end
      n_cmp++;
      if (fact !== exps[k]) begin
        n_bad++;
        $display("FAIL small_fact n=%0d got=%0d want=%0d", ops[k], fact, exps[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  ops  [3] = '{4'd8, 4'd9, 4'd15};
    logic [15:0] exps [3] = '{16'd40320, 16'd35200, 16'd22528};
    int          lats [3] = '{7, 8, 14};
    int edges;
    for (int k = 0; k < 3; k++) begin
      release_start();
      start = 1'b1;
      data1 = ops[k];
      wait_done(edges);
      n_cmp++;
      if (edges != lats[k]) begin
        n_bad++;
        $display("FAIL wrap_latency n=%0d got=%0d want=%0d", ops[k], edges, lats[k]);
      end
      n_cmp++;
      if (fact !== exps[k]) begin
        n_bad++;
        $display("FAIL wrap_fact n=%0d got=%0d want=%0d", ops[k], fact, exps[k]);
      end
    end
  endtask

  task automatic test_hold();
    int edges;
    release_start();
    start = 1'b1;
    data1 = 4'd4;
    wait_done(edges);
    n_cmp++;
    if (fact !== 16'd24 || edges != 3) begin
      n_bad++;
      $display("FAIL hold_first got=%0d/%0d want=24/3", fact, edges);
    end
    data1 = 4'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (done !== 1'b1 || fact !== 16'd24) begin
        n_bad++;
        $display("FAIL hold_stable cyc=%0d got=%0b/%0d want=1/24", i, done, fact);
      end
    end
    start = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b0 || fact !== 16'd24) begin
      n_bad++;
      $display("FAIL hold_drop got=%0b/%0d want=0/24", done, fact);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || fact !== 16'd24) begin
      n_bad++;
      $display("FAIL hold_idle got=%0b/%0d want=0/24", done, fact);
    end
    start = 1'b1;
    data1 = 4'd3;
    wait_done(edges);
    n_cmp++;
    if (fact !== 16'd6 || edges != 2) begin
      n_bad++;
      $display("FAIL hold_rerun got=%0d/%0d want=6/2", fact, edges);
    end
  endtask

  task automatic test_abort();
    int edges;
    release_start();
    start = 1'b1;
    data1 = 4'd7;
    tick();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (done !== 1'b0 || fact !== 16'd0) begin
      n_bad++;
      $display("FAIL abort_clear got=%0b/%0d want=0/0", done, fact);
    end
    reset_n = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (done !== 1'b0 || fact !== 16'd0) begin
      n_bad++;
      $display("FAIL abort_idle got=%0b/%0d want=0/0", done, fact);
    end
    start = 1'b1;
    data1 = 4'd5;
    wait_done(edges);
    n_cmp++;
    if (fact !== 16'd120 || edges != 4) begin
      n_bad++;
      $display("FAIL abort_rerun got=%0d/%0d want=120/4", fact, edges);
    end
  endtask

  task automatic test_data_change();
    int edges;
    release_start();
    start = 1'b1;
    data1 = 4'd5;
    tick();
    edges = 0;
    for (int i = 0; i < 30; i++) begin
      data1 = 4'(15 - i);
      tick();
      edges++;
      if (done) break;
    end
    n_cmp++;
    if (edges != 4) begin
      n_bad++;
      $display("FAIL datachg_latency got=%0d want=4", edges);
    end
    n_cmp++;
    if (fact !== 16'd120) begin
      n_bad++;
      $display("FAIL datachg_fact got=%0d want=120", fact);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    data1   = 4'd0;
    #1;
    test_reset();
    test_small();
    test_wrap();
    test_hold();
    test_abort();
    test_data_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
